sub_16_serial: RTL and testbench
================================

# sub_16_serial

Bit-serial 16-bit subtractor with borrow-in/borrow-out and a start/busy/done handshake. It computes diff = a - b - b_in, one bit per clock, LSB first, through a single 1-bit full subtractor. It is the subtraction counterpart to the 16-bit ripple-carry adder and trades 16 cycles of latency for a one-cell datapath. Its outputs are bit-compatible with a combinational 16-bit subtractor, so the same exhaustive benches can drive both.

## Interface
- WIDTH, 16, operand and result width in bits; supported range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  request; sampled on a rising edge only when the block is not busy.
- a  in  WIDTH  minuend; sampled with start.
- b  in  WIDTH  subtrahend; sampled with start.
- b_in  in  1  borrow-in; sampled with start.
- busy  out  1  high while a subtraction is in progress.
- done  out  1  one-cycle pulse; diff and b_out are valid.
- diff  out  WIDTH  result, a - b - b_in modulo 2^WIDTH.
- b_out  out  1  final borrow; 1 when a < b + b_in, unsigned.

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT: one bit processed per cycle.
  - DONE: a single-cycle state.
- IDLE with start=1:
  - latch a into sh_a, b into sh_b, and b_in into the borrow flop;
  - clear bit counter cnt;
  - go to SHIFT.
- SHIFT, per edge:
  - d = sh_a[0] ^ sh_b[0] ^ brw;
  - brw' = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & brw);
  - shift d into the MSB of the result register, moving the result right;
  - shift sh_a and sh_b right by 1;
  - cnt++.
- When cnt reaches WIDTH-1 on that edge, go to DONE.
- DONE:
  - done=1 for one cycle;
  - diff holds the full result and b_out = brw;
  - next state is IDLE, or SHIFT if start=1 in that cycle (a new request is accepted).
- diff and b_out keep the last result until the next DONE. They do not change during SHIFT: the result is staged in an internal shift register and copied to diff/b_out on the edge entering DONE.
- start while busy=1 is ignored. There is no queueing.
- Operands are captured at the start edge. Input changes during SHIFT have no effect.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE, busy=0, done=0, diff=0, b_out=0, cnt=0, all shift registers 0.
- If reset occurs during SHIFT, the operation is lost and no done is produced. Operation resumes from IDLE on the first edge after rst_n rises.
- Start sampled at edge N:
  - busy=1 from after edge N through edge N+WIDTH;
  - done=1 in the cycle after edge N+WIDTH, when busy drops to 0.
  - Latency is WIDTH+1 cycles from the start edge to the done cycle, 17 for the default.
- Back-to-back requests: start held high during the done cycle begins the next operation. Maximum throughput is one result per WIDTH+1 cycles.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- SUB_SERIAL_OVF_EN:
  - Defined: adds output port ovf (out, 1), the signed two's-complement overflow of a - b - b_in. ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the latched a/b MSBs. It is registered and updated with diff; reset value 0.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package sub_serial_pkg holds:
  - the state enum {IDLE, SHIFT, DONE};
  - the default WIDTH constant;
  - the counter width $clog2(WIDTH).
- One sub-module, fs_1: a combinational 1-bit full subtractor with ports x, y, bi, d, bo. It is instantiated once in the datapath.

## Test plan
- Reset mid-operation: pulse rst_n low 5 cycles after start -> busy=0, done=0, diff=0, b_out=0 immediately, and no later done pulse.
- Basic subtraction: a=0x0005, b=0x0003, b_in=0 -> done at cycle N+17, diff=0x0002, b_out=0, busy high for exactly 16 cycles.
- Underflow: a=0x0000, b=0x0001, b_in=0 -> diff=0xFFFF, b_out=1. With the macro defined, also ovf=0.
- Borrow-in and signed overflow:
  - a=0xFFFF, b=0xFFFF, b_in=1 -> diff=0xFFFF, b_out=1.
  - a=0x8000, b=0x0001, b_in=0 -> diff=0x7FFF, b_out=0, ovf=1 (macro defined).
- Handshake:
  - start held continuously -> one done every 17 cycles;
  - a second start while busy -> ignored, and the original operands' result is returned.
- Sweep: for i in 0..65535, a=i, b=i with b_in=0 -> diff=0, b_out=0; with b_in=1 -> diff=0xFFFF, b_out=1. Each result is compared against a behavioural a-b-b_in model.

Source files
------------

// File: rtl/sub_serial_pkg.sv
// sub_serial_pkg: shared state encoding and sizing for the bit-serial subtractor.
package sub_serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/fs_1.sv
// fs_1: combinational 1-bit full subtractor, d = x - y - bi.
module fs_1 (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/sub_16_serial.sv
// sub_16_serial: bit-serial a - b - b_in, LSB first, with start/busy/done handshake.
// Define SUB_SERIAL_OVF_EN to add the registered signed-overflow output ovf_o.
module sub_16_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             b_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             b_out_o
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic             ovf_o
`endif
);
  localparam int CW = cnt_w(WIDTH);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d, b_out_q, b_out_d, d, bo, last;
  fs_1 u_fs (.x(sh_a_q[0]), .y(sh_b_q[0]), .bi(brw_q), .d(d), .bo(bo));
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    b_out_d = b_out_q;
    if (state_q == SHIFT) begin
      sh_a_d = sh_a_q >> 1;
      sh_b_d = sh_b_q >> 1;
      res_d  = {d, res_q[WIDTH-1:1]};
      brw_d  = bo;
      cnt_d  = cnt_q + 1'b1;
      if (last) begin
        state_d = DONE;
        diff_d  = {d, res_q[WIDTH-1:1]};
        b_out_d = bo;
      end
    end else if (start_i) begin
      state_d = SHIFT;
      sh_a_d  = a_i;
      sh_b_d  = b_i;
      brw_d   = b_in_i;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      b_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      b_out_q <= b_out_d;
    end
  end
  assign busy_o  = state_q == SHIFT;
  assign done_o  = state_q == DONE;
  assign diff_o  = diff_q;
  assign b_out_o = b_out_q;
`ifdef SUB_SERIAL_OVF_EN
  // On the final bit the shifters hold the operand MSBs and d is the result MSB.
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (state_q == SHIFT && last) ovf_q <= (sh_a_q[0] ^ sh_b_q[0]) & (d ^ sh_a_q[0]);
  end
  assign ovf_o = ovf_q;
`endif
endmodule

// File: tb/tb_sub_16_serial.sv
// tb_sub_16_serial: directed plus randomized checks of sub_16_serial against an arithmetic model.
module tb_sub_16_serial;
  localparam int W = 16;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, b_in = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, b_out;
  logic [W-1:0] diff;
`ifdef SUB_SERIAL_OVF_EN
  logic ovf;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sub_16_serial dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b), .b_in_i(b_in),
    .busy_o(busy), .done_o(done), .diff_o(diff), .b_out_o(b_out)
`ifdef SUB_SERIAL_OVF_EN
    , .ovf_o(ovf)
`endif
  );
  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // {borrow, diff}: the wrapped (W+1)-bit difference carries the borrow in its top bit.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
  endfunction
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0] r;
    r = ref_sub(x, y, bi);
    return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
  endfunction
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi, input string tag);
    int k, bc;
    @(negedge clk);
    a = x; b = y; b_in = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
    k = 1; bc = 0;
    while (!done && k < 40) begin
      bc += int'(busy);
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, (W+1)'(k), (W+1)'(17));
    chk({tag, " busy_cycles"}, (W+1)'(bc), (W+1)'(16));
    chk({tag, " busy_at_done"}, (W+1)'(busy), '0);
    chk({tag, " result"}, {b_out, diff}, ref_sub(x, y, bi));
`ifdef SUB_SERIAL_OVF_EN
    chk({tag, " ovf"}, (W+1)'(ovf), (W+1)'(ref_ovf(x, y, bi)));
`endif
    @(negedge clk);
    chk({tag, " done_pulse"}, (W+1)'(done), '0);
  endtask
  initial begin
    logic [W:0] q[$];
    logic [W:0] held;
    logic [W-1:0] v;
    int k, bc;
    #12;
    chk("rst busy", (W+1)'(busy), '0);
    chk("rst done", (W+1)'(done), '0);
    chk("rst result", {b_out, diff}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0005, 16'h0003, 1'b0, "basic");
    do_op(16'h0000, 16'h0001, 1'b0, "underflow");
    do_op(16'hFFFF, 16'hFFFF, 1'b1, "borrow_in");
    do_op(16'h8000, 16'h0001, 1'b0, "signed_ovf");
    do_op(16'h7FFF, 16'hFFFF, 1'b0, "signed_ovf2");
    // Second start while busy must be dropped; diff must hold the old result meanwhile.
    held = {b_out, diff};
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignored hold_during_shift", {b_out, diff}, held);
    k = 0;
    while (!done && k < 40) begin @(negedge clk); k++; end
    chk("ignored latency", (W+1)'(k), (W+1)'(11));
    chk("ignored result", {b_out, diff}, ref_sub(16'h1234, 16'h0234, 1'b0));
    repeat (3) @(negedge clk);
    chk("ignored no_second_done", (W+1)'(done), '0);
    // Start held high: a new operand set is presented at each done cycle.
    a = W'($urandom); b = W'($urandom); b_in = 1'($urandom); start = 1'b1;
    q.push_back(ref_sub(a, b, b_in));
    for (int n = 0; n < 4; n++) begin
      k = 0;
      do begin @(negedge clk); k++; end while (!done && k < 40);
      chk("b2b interval", (W+1)'(k), (W+1)'(17));
      chk("b2b result", {b_out, diff}, q.pop_front());
      if (n < 3) begin
        a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
        q.push_back(ref_sub(a, b, b_in));
      end else start = 1'b0;
    end
    // Reset in the middle of a SHIFT clears everything and loses the operation.
    do_op(16'hBEEF, 16'h1234, 1'b1, "pre_reset");
    @(negedge clk);
    a = 16'h0005; b = 16'h0003; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", (W+1)'(busy), '0);
    chk("midrst done", (W+1)'(done), '0);
    chk("midrst result", {b_out, diff}, '0);
`ifdef SUB_SERIAL_OVF_EN
    chk("midrst ovf", (W+1)'(ovf), '0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    bc = 0;
    repeat (30) begin @(negedge clk); bc += int'(done); end
    chk("midrst no_done", (W+1)'(bc), '0);
    // Sampled a == b sweep, including both ends of the range.
    for (int i = 0; i < 20; i++) begin
      v = (i == 0) ? 16'h0000 : (i == 1) ? 16'hFFFF : W'($urandom);
      do_op(v, v, 1'b0, "sweep bin0");
      do_op(v, v, 1'b1, "sweep bin1");
    end
    for (int i = 0; i < 100; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), "random");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
